// File: rtl/fir_folded_pkg.sv
// fir_folded_pkg: shared types and helpers for the folded FIR filter.
//   firState_e - controller states (IDLE / MAC / OUT)
//   accWidth() - accumulator width: DIN_W + COEF_W + $clog2(TAPS)
//   satClamp() - clamp a signed value into a w-bit two's-complement range
package fir_folded_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MAC  = 2'd1,
        OUT  = 2'd2
    } firState_e;

    // Wide enough that summing TAPS full-width products can never overflow
    function automatic int unsigned accWidth(input int unsigned dinW,
                                             input int unsigned coefW,
                                             input int unsigned taps);
        return dinW + coefW + $clog2(taps);
    endfunction

    function automatic logic signed [63:0] satClamp(input logic signed [63:0] v,
                                                    input int unsigned w);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (w - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (w - 1));
        if (v > hi) begin
            return hi;
        end else if (v < lo) begin
            return lo;
        end
        return v;
    endfunction

endpackage

// File: rtl/fir_coef_bank.sv
// fir_coef_bank: double-buffered coefficient store for the folded FIR.
// Host writes and reads always target the shadow bank. A swap request is
// held pending until the controller reports idle, so a running output never
// mixes coefficients from both banks.
// Ports:
//   iClk_12M, iRsn        clock, async active-low reset
//   idle                  controller is in IDLE (swap may execute)
//   iCsnRam, iWrnRam      host select (active-low) and 0=write / 1=read
//   iAddrRam, iWrDtRam    host tap address and write data
//   oRdDtRam              registered shadow-bank read data
//   iCoeffiUpdateFlag     swap request pulse
//   rdIdx, coefActive     combinational active-bank read for the MAC
module fir_coef_bank
    import fir_folded_pkg::*;
#(
    parameter int unsigned TAPS   = 33,
    parameter int unsigned COEF_W = 16,
    parameter int unsigned AW     = $clog2(TAPS)
) (
    input  logic              iClk_12M,
    input  logic              iRsn,
    input  logic              idle,
    input  logic              iCsnRam,
    input  logic              iWrnRam,
    input  logic [AW-1:0]     iAddrRam,
    input  logic [COEF_W-1:0] iWrDtRam,
    output logic [COEF_W-1:0] oRdDtRam,
    input  logic              iCoeffiUpdateFlag,
    input  logic [AW-1:0]     rdIdx,
    output logic [COEF_W-1:0] coefActive
);

    logic [COEF_W-1:0] bank0 [TAPS];
    logic [COEF_W-1:0] bank1 [TAPS];
    logic              bankSel;      // 0: bank0 active, 1: bank1 active
    logic              swapPending;

    logic addrOk_c;
    logic hostWr_c;
    logic hostRd_c;
    logic doSwap_c;

    assign addrOk_c = 32'(iAddrRam) < TAPS;
    assign hostWr_c = !iCsnRam && !iWrnRam && addrOk_c;
    assign hostRd_c = !iCsnRam && iWrnRam;
    assign doSwap_c = swapPending && idle;

    assign coefActive = bankSel ? bank1[rdIdx] : bank0[rdIdx];

    // Banks, bank select, swap request and host read register
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            for (int unsigned k = 0; k < TAPS; k++) begin
                bank0[k] <= '0;
                bank1[k] <= '0;
            end
            bankSel     <= 1'b0;
            swapPending <= 1'b0;
            oRdDtRam    <= '0;
        end else begin
            // Shadow is selected with the pre-swap bankSel, so a write on the
            // swap edge lands in the bank that is about to become active.
            if (hostWr_c) begin
                if (bankSel) begin
                    bank0[iAddrRam] <= iWrDtRam;
                end else begin
                    bank1[iAddrRam] <= iWrDtRam;
                end
            end
            if (hostRd_c) begin
                if (!addrOk_c) begin
                    oRdDtRam <= '0;
                end else begin
                    oRdDtRam <= bankSel ? bank0[iAddrRam] : bank1[iAddrRam];
                end
            end
            // A request arriving on the swap edge is absorbed into that swap
            if (doSwap_c) begin
                bankSel     <= ~bankSel;
                swapPending <= 1'b0;
            end else if (iCoeffiUpdateFlag) begin
                swapPending <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/fir_filter_folded.sv
// fir_filter_folded: time-multiplexed direct-form FIR. One multiply-accumulate
// unit walks all TAPS coefficients per accepted sample (TAPS+2 cycles/sample).
// Optional feature: define FIR_FOLDED_SAT_EN to clamp the output instead of
// wrapping it to DOUT_W bits.
// Ports:
//   iClk_12M, iRsn            clock, async active-low reset
//   iInValid, oInReady        sample handshake (ready only in IDLE)
//   iFirIn                    signed input sample
//   oOutValid, oFirOut        one-cycle output pulse, output held between pulses
//   iCsnRam, iWrnRam,
//   iAddrRam, iWrDtRam,
//   oRdDtRam                  host coefficient port (shadow bank)
//   iCoeffiUpdateFlag         shadow/active bank swap request
module fir_filter_folded
    import fir_folded_pkg::*;
#(
    parameter int unsigned TAPS      = 33,
    parameter int unsigned DIN_W     = 3,
    parameter int unsigned COEF_W    = 16,
    parameter int unsigned DOUT_W    = 16,
    parameter int unsigned OUT_SHIFT = 0,
    parameter int unsigned AW        = $clog2(TAPS)
) (
    input  logic              iClk_12M,
    input  logic              iRsn,
    input  logic              iInValid,
    output logic              oInReady,
    input  logic [DIN_W-1:0]  iFirIn,
    output logic              oOutValid,
    output logic [DOUT_W-1:0] oFirOut,
    input  logic              iCsnRam,
    input  logic              iWrnRam,
    input  logic [AW-1:0]     iAddrRam,
    input  logic [COEF_W-1:0] iWrDtRam,
    output logic [COEF_W-1:0] oRdDtRam,
    input  logic              iCoeffiUpdateFlag
);

    localparam int unsigned ACC_W  = accWidth(DIN_W, COEF_W, TAPS);
    localparam int unsigned PROD_W = DIN_W + COEF_W;

    firState_e                state;
    logic [AW-1:0]            idx;
    logic signed [ACC_W-1:0]  acc;
    logic signed [DIN_W-1:0]  delayLine [TAPS];
    logic signed [COEF_W-1:0] coefActive;

    logic signed [PROD_W-1:0] prod_c;
    logic signed [ACC_W-1:0]  accShift_c;
    logic [DOUT_W-1:0]        scaled_c;

    fir_coef_bank #(
        .TAPS   (TAPS),
        .COEF_W (COEF_W),
        .AW     (AW)
    ) u_coefBank (
        .iClk_12M          (iClk_12M),
        .iRsn              (iRsn),
        .idle              (state == IDLE),
        .iCsnRam           (iCsnRam),
        .iWrnRam           (iWrnRam),
        .iAddrRam          (iAddrRam),
        .iWrDtRam          (iWrDtRam),
        .oRdDtRam          (oRdDtRam),
        .iCoeffiUpdateFlag (iCoeffiUpdateFlag),
        .rdIdx             (idx),
        .coefActive        (coefActive)
    );

    // Decoded straight from the state register; forced low while in reset
    assign oInReady = iRsn && (state == IDLE);

    assign prod_c     = PROD_W'(delayLine[idx]) * PROD_W'(coefActive);
    assign accShift_c = acc >>> OUT_SHIFT;

`ifdef FIR_FOLDED_SAT_EN
    assign scaled_c = DOUT_W'(satClamp(64'(accShift_c), DOUT_W));
`else
    assign scaled_c = DOUT_W'(accShift_c);
`endif

    // Controller, delay line, accumulator and output register
    always_ff @(posedge iClk_12M or negedge iRsn) begin
        if (!iRsn) begin
            state     <= IDLE;
            idx       <= '0;
            acc       <= '0;
            oOutValid <= 1'b0;
            oFirOut   <= '0;
            for (int unsigned k = 0; k < TAPS; k++) begin
                delayLine[k] <= '0;
            end
        end else begin
            oOutValid <= 1'b0;
            unique case (state)
                IDLE: begin
                    // oInReady is high throughout IDLE, so valid alone accepts
                    if (iInValid) begin
                        delayLine[0] <= iFirIn;
                        for (int unsigned k = 1; k < TAPS; k++) begin
                            delayLine[k] <= delayLine[k-1];
                        end
                        acc   <= '0;
                        idx   <= '0;
                        state <= MAC;
                    end
                end
                MAC: begin
                    acc <= acc + ACC_W'(prod_c);
                    if (idx == AW'(TAPS - 1)) begin
                        state <= OUT;
                    end else begin
                        idx <= idx + AW'(1);
                    end
                end
                OUT: begin
                    oFirOut   <= scaled_c;
                    oOutValid <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
